// File: rtl/alu_stage_exec_unit_if.sv
// Execute-unit bus: decoded op and register reads in,
// stage number, ALU debug view and latched result out.
interface alu_stage_exec_unit_if;
  logic [4:0]  alu_operation;
  logic [31:0] reg_value_0;
  logic [31:0] reg_value_1;
  logic [2:0]  current_stage;
  logic [31:0] alu_in0;
  logic [31:0] alu_in1;
  logic [4:0]  alu_op_select;
  logic [31:0] alu_result;
  logic [31:0] result_q;
  logic        result_valid;

  modport master (
    output alu_operation,
    output reg_value_0,
    output reg_value_1,
    input  current_stage,
    input  alu_in0,
    input  alu_in1,
    input  alu_op_select,
    input  alu_result,
    input  result_q,
    input  result_valid
  );

  modport slave (
    input  alu_operation,
    input  reg_value_0,
    input  reg_value_1,
    output current_stage,
    output alu_in0,
    output alu_in1,
    output alu_op_select,
    output alu_result,
    output result_q,
    output result_valid
  );
endinterface

// File: rtl/alu_stage_exec_unit.sv
// Execute block: modulo stage counter, ALU control,
// 32-bit ALU and a result register loaded in EXEC_STAGE.
module alu_stage_exec_unit #(
  parameter int NUM_STAGES = 5,
  parameter int EXEC_STAGE = 2
) (
  input logic                 clk,
  input logic                 rst,
  alu_stage_exec_unit_if.slave bus
);

  localparam logic [2:0] LAST = 3'(NUM_STAGES - 1);
  localparam logic [2:0] EXEC = 3'(EXEC_STAGE);

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4;
  localparam logic [4:0] OP_SLL  = 5'd5;
  localparam logic [4:0] OP_SRL  = 5'd6;
  localparam logic [4:0] OP_SRA  = 5'd7;
  localparam logic [4:0] OP_SLT  = 5'd8;
  localparam logic [4:0] OP_SLTU = 5'd9;
  localparam logic [4:0] OP_MUL  = 5'd10;
  localparam logic [4:0] OP_NOP  = 5'd31;

  logic [2:0]  stage_q, stage_d;
  logic [31:0] res_q, res_d;
  logic        valid_q, valid_d;

  logic [4:0]  sel;
  logic [31:0] a, b, y;
  logic [4:0]  shamt;

  always_comb begin
    a     = bus.reg_value_0;
    b     = bus.reg_value_1;
    shamt = b[4:0];
    sel   = (bus.alu_operation <= OP_MUL)
          ? bus.alu_operation : OP_NOP;
  end

  always_comb begin
    y = '0;
    unique case (sel)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_SLL:  y = a << shamt;
      OP_SRL:  y = a >> shamt;
      OP_SRA:  y = $signed(a) >>> shamt;
      OP_SLT:  y = {31'd0, $signed(a) < $signed(b)};
      OP_SLTU: y = {31'd0, a < b};
      OP_MUL:  y = a * b;
      default: y = '0;
    endcase
  end

  always_comb begin
    stage_d = (stage_q == LAST) ? 3'd0 : stage_q + 3'd1;
    res_d   = res_q;
    valid_d = 1'b0;
    if (stage_q == EXEC) begin
      res_d   = y;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stage_q <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      stage_q <= stage_d;
      res_q   <= res_d;
      valid_q <= valid_d;
    end
  end

  assign bus.current_stage = stage_q;
  assign bus.alu_in0       = a;
  assign bus.alu_in1       = b;
  assign bus.alu_op_select = sel;
  assign bus.alu_result    = y;
  assign bus.result_q      = res_q;
  assign bus.result_valid  = valid_q;

endmodule

// File: tb/tb_alu_stage_exec_unit.sv
// Directed and random checks of alu_stage_exec_unit
// against a behavioural stage/ALU model.
module tb_alu_stage_exec_unit;

  localparam int N  = 5;
  localparam int EX = 2;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  int          m_stage;
  logic [31:0] m_res;
  logic        m_valid;

  alu_stage_exec_unit_if bus ();

  alu_stage_exec_unit #(
    .NUM_STAGES(N),
    .EXEC_STAGE(EX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(
    input int op, input logic [31:0] a,
    input logic [31:0] b);
    longint unsigned p;
    int sh;
    sh = int'(b) & 31;
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return a << sh;
      6: return a >> sh;
      7: begin
        if (a[31])
          return ~((~a) >> sh);
        return a >> sh;
      end
      8: return (int'(a) < int'(b)) ? 1 : 0;
      9: return (a < b) ? 1 : 0;
      10: begin
        p = longint'(a) * longint'(b);
        return p[31:0];
      end
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    int op;
    op = int'(bus.alu_operation);
    if (!rst) begin
      m_stage = 0;
      m_res   = 0;
      m_valid = 0;
    end else begin
      m_valid = (m_stage == EX);
      if (m_valid)
        m_res = ref_alu(op, bus.reg_value_0,
                        bus.reg_value_1);
      m_stage = (m_stage + 1) % N;
    end
    @(posedge clk);
    @(negedge clk);
    chk("stage", 32'(bus.current_stage),
        32'(m_stage));
    chk("result_q", bus.result_q, m_res);
    chk("valid", 32'(bus.result_valid),
        32'(m_valid));
    chk("alu_result", bus.alu_result,
        ref_alu(op, bus.reg_value_0,
                bus.reg_value_1));
    chk("op_select", 32'(bus.alu_op_select),
        (op <= 10) ? 32'(op) : 32'd31);
    chk("alu_in0", bus.alu_in0, bus.reg_value_0);
  endtask

  task automatic dvec(input string tag,
                      input logic [4:0] op,
                      input logic [31:0] a,
                      input logic [31:0] b,
                      input logic [31:0] exp);
    bus.alu_operation = op;
    bus.reg_value_0   = a;
    bus.reg_value_1   = b;
    step();
    chk(tag, bus.alu_result, exp);
  endtask

  initial begin
    int guard;
    n_assert = 0;
    n_fail   = 0;
    m_stage  = 0;
    m_res    = 0;
    m_valid  = 0;
    rst               = 1'b0;
    bus.alu_operation = '0;
    bus.reg_value_0   = '0;
    bus.reg_value_1   = '0;

    step();
    step();
    rst = 1'b1;
    for (int i = 0; i < 7; i++) step();

    dvec("add_wrap", 5'd0, 32'hFFFFFFFF, 32'd1, 32'd0);
    dvec("sub_wrap", 5'd1, 32'd0, 32'd1, 32'hFFFFFFFF);
    dvec("mul_low", 5'd10, 32'h10000, 32'h10000, 32'd0);
    dvec("and", 5'd2, 32'hF0F0F0F0, 32'h0FF00FF0,
         32'h00F000F0);
    dvec("or", 5'd3, 32'hF0F0F0F0, 32'h0FF00FF0,
         32'hFFF0FFF0);
    dvec("xor", 5'd4, 32'hF0F0F0F0, 32'h0FF00FF0,
         32'hFF00FF00);
    dvec("sll", 5'd5, 32'h1, 32'h24, 32'h10);
    dvec("srl", 5'd6, 32'h80000000, 32'h24,
         32'h08000000);
    dvec("sra", 5'd7, 32'h80000000, 32'h24,
         32'hF8000000);
    dvec("slt", 5'd8, 32'hFFFFFFFF, 32'd1, 32'd1);
    dvec("sltu", 5'd9, 32'hFFFFFFFF, 32'd1, 32'd0);
    dvec("slt_eq", 5'd8, 32'd9, 32'd9, 32'd0);
    dvec("sltu_eq", 5'd9, 32'd9, 32'd9, 32'd0);
    dvec("nop17", 5'd17, 32'd3, 32'd4, 32'd0);
    chk("nop_sel", 32'(bus.alu_op_select), 32'd31);

    guard = 0;
    while (m_stage != 3 && guard < 10) begin
      step();
      guard++;
    end
    chk("reach_stage3", 32'(bus.current_stage), 32'd3);
    rst = 1'b0;
    step();
    chk("midreset", 32'(bus.current_stage), 32'd0);
    rst = 1'b1;

    bus.alu_operation = 5'd0;
    bus.reg_value_0   = 32'd7;
    bus.reg_value_1   = 32'd5;
    for (int i = 0; i < 2 * N; i++) begin
      step();
      chk("valid_stage3",
          32'(bus.result_valid),
          32'(bus.current_stage == 3'd3));
    end
    chk("latch12", bus.result_q, 32'd12);

    for (int i = 0; i < 300; i++) begin
      bus.alu_operation = 5'($urandom_range(0, 31));
      bus.reg_value_0   = $urandom;
      bus.reg_value_1   = $urandom;
      if (i % 4 == 0) bus.reg_value_0 = 32'($urandom_range(0, 3));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_stage_exec_unit.md
Name: alu_stage_exec_unit

Overview:
Execute-side block of the multi-cycle CPU. It combines three parts:
- a modulo-N stage counter that sequences the pipeline stages;
- an ALU control stage that maps the decoded operation code onto an ALU select and routes register-file read values to the ALU operands;
- a 32-bit combinational ALU.

The ALU result is also captured into a result register during the execute stage, for use by register-file write-back.

Parameters:
- NUM_STAGES, 5, counter modulus; legal range 2..8; stage count runs 0..NUM_STAGES-1.
- EXEC_STAGE, 2, stage index at which the ALU result is latched; must be < NUM_STAGES.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset.
- alu_operation  input  5  decoded ALU operation code.
- reg_value_0  input  32  register-file read data, port 0.
- reg_value_1  input  32  register-file read data, port 1.
- current_stage  output  3  current stage number.
- alu_in0  output  32  ALU operand 0 (debug visibility).
- alu_in1  output  32  ALU operand 1 (debug visibility).
- alu_op_select  output  5  ALU select (debug visibility).
- alu_result  output  32  combinational ALU output.
- result_q  output  32  latched ALU result.
- result_valid  output  1  one-cycle pulse: result_q updated.

Behaviour:
- Reset: on a rising clk with rst==0:
  - current_stage <= 0, result_q <= 0, result_valid <= 0;
  - reset takes priority over all other updates;
  - reset asserted mid-sequence restarts at stage 0 on the next edge.
- Stage counter, when rst==1:
  - current_stage increments by 1 each cycle;
  - at NUM_STAGES-1 it wraps to 0;
  - no enable input; counts continuously.
- ALU control (combinational):
  - alu_in0 = reg_value_0, alu_in1 = reg_value_1;
  - alu_op_select = alu_operation for codes 0..10;
  - any code 11..31 maps to 31 (NOP).
- ALU select encodings (combinational, 32-bit, no carry/overflow outputs):
  - 0 ADD: in0+in1, modulo 2^32.
  - 1 SUB: in0-in1, modulo 2^32.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 SLL: in0 << in1[4:0].
  - 6 SRL: logical, in0 >> in1[4:0].
  - 7 SRA: arithmetic, in0 >>> in1[4:0].
  - 8 SLT: 1 if signed in0 < in1, else 0.
  - 9 SLTU: 1 if unsigned in0 < in1, else 0.
  - 10 MUL: low 32 bits of the unsigned product.
  - 31, and any other select value: output 0.
- Shift amount: upper bits in1[31:5] are ignored for shifts.
- Result latch, on a rising edge with rst==1:
  - if current_stage==EXEC_STAGE: result_q <= alu_result and result_valid <= 1;
  - otherwise result_q holds and result_valid <= 0;
  - result_valid is therefore high exactly in stage EXEC_STAGE+1 (mod NUM_STAGES), once per stage round.
- Latency: alu_result has zero latency from its inputs; result_q has one clock latency relative to the EXEC_STAGE cycle.

Test Plan:
- Reset and wrap: hold rst=0 for 2 cycles, then release → current_stage 0,1,2,3,4,0,1…; result_q=0 and result_valid=0 throughout reset. Reassert rst while current_stage=3 → 0 after the next edge.
- Arithmetic: op 0 with 0xFFFFFFFF,1 → 0. Op 1 with 0,1 → 0xFFFFFFFF. Op 10 with 0x10000,0x10000 → 0.
- Logic/shift: op 2/3/4 with 0xF0F0F0F0,0x0FF00FF0 → 0x00F000F0 / 0xFFF0FFF0 / 0xFF00FF00.
- Shifts with shift amount 0x24: op 5 on 0x00000001 → 0x10. Op 6 on 0x80000000 → 0x08000000. Op 7 on 0x80000000 → 0xF8000000.
- Compares: op 8 with 0xFFFFFFFF,1 → 1. Op 9 with same operands → 0. Equal operands → 0 for both.
- Control and latch: op 17 → alu_op_select=31, alu_result=0. Op 0 with 7,5 held across a full round → result_q becomes 12 and result_valid pulses for one cycle in stage 3 only; result_q is unchanged in all other stages.
